jk_mod_counter: RTL and testbench
=================================

Name: jk_mod_counter

Overview:
- Synchronous modulo-N up/down counter whose state bits follow JK flip-flop excitation: each bit's next state is J&~q | ~K&q.
- Sits directly downstream of the master-slave JK flip-flop stage. It consumes the same per-bit q/qbar/J/K convention and produces a count vector plus terminal-count and wrap flags for later stages.
- J/K excitation vectors are exported so they can be cross-checked against discrete flip-flop instances.

Parameters:
- WIDTH, 4, counter bit width; legal range 1..16.
- MODULUS, 10, count range 0..MODULUS-1; legal range 2..2^WIDTH. Any other value is a configuration error and is flagged at elaboration.

Ports:
- clock  input  1  rising-edge clock for all state.
- clear  input  1  asynchronous active-high reset.
- en     input  1  count enable.
- up     input  1  direction: 1 = increment, 0 = decrement.
- load   input  1  synchronous parallel load request.
- din    input  WIDTH  load value.
- q      output WIDTH  current count (registered).
- qbar   output WIDTH  bitwise complement of q, always exactly ~q.
- j_vec  output WIDTH  combinational J excitation for the next edge.
- k_vec  output WIDTH  combinational K excitation for the next edge.
- tc     output 1  combinational terminal count.
- wrap   output 1  registered one-cycle pulse.

Behaviour:
- Reset:
  - clear high forces q=0 and wrap=0 immediately, independent of clock; qbar therefore = all ones.
  - q holds 0 while clear stays high. The first update happens on the first rising edge after clear falls.
  - clear asserted mid-count aborts the count with no wrap pulse.
- Priority on each rising edge: clear > load > en > hold.
- Load:
  - load=1 sets q_next = din when din <= MODULUS-1, otherwise q_next = MODULUS-1 (clamp).
  - load overrides en and up. Load never produces a wrap pulse.
- Count, en=1 and load=0:
  - up=1: q_next = q+1, or 0 when q = MODULUS-1.
  - up=0: q_next = q-1, or MODULUS-1 when q = 0.
  - Arithmetic is unsigned and modulo MODULUS. q never leaves 0..MODULUS-1.
- Hold: en=0 and load=0 gives q_next = q.
- JK excitation, per bit i:
  - j_vec[i] = ~q[i] & q_next[i]
  - k_vec[i] = q[i] & ~q_next[i]
  - Bits that do not change have j=k=0. j_vec & k_vec is always 0 (the toggle code is never used).
  - The state register is updated only through these J/K equations: q <= (j_vec & ~q) | (~k_vec & q).
- tc:
  - tc = en & ~load & ((up & q==MODULUS-1) | (~up & q==0)).
  - It is combinational, so it changes within the cycle when en or up changes.
- wrap:
  - Goes high for exactly one cycle after any edge where tc was 1 and the count wrapped.
  - Consecutive wraps (for example MODULUS=2 counting continuously) give back-to-back pulses.
- Direction change: an up toggle takes effect on the next edge. There is no pipeline delay, and latency is one clock from input to q.
- Power-of-two MODULUS (for example 16 with WIDTH=4) wraps naturally, with identical tc and wrap behaviour.

Test Plan:
1. Reset, count up: assert clear mid-cycle, release; en=1, up=1 for 12 edges.
   - q = 0 during clear.
   - q runs 1..9, then 0, 1, 2.
   - tc high during the cycle q=9.
   - wrap high for the cycle after 9->0.
2. Count down across zero: load din=1, then en=1, up=0 for 3 edges.
   - q sequence 1, 0, 9, 8.
   - tc high while q=0.
   - wrap pulse after 0->9.
3. Load clamp and priority: din=12, load=1, en=1, up=1.
   - q = 9 next edge, no wrap.
   - Then din=5, load=1: q = 5.
4. Hold and excitation check: q=7, en=0 for 4 edges.
   - q stays 7, tc=0, j_vec=k_vec=0.
   - Then en=1, up=1 (7->8): j_vec=4'b1000, k_vec=4'b0111.
   - Assert j_vec&k_vec==0 and qbar==~q every cycle.
5. Async clear mid-count: q=6 counting up; assert clear between edges.
   - q = 0 before the next edge, wrap=0.
   - Hold clear across 2 edges: q stays 0.
   - Release: next edge gives q=1.
6. Random regression, MODULUS=2 and MODULUS=16 builds: compare q, tc and wrap every cycle against a reference model for 2000 cycles of random en/up/load/din/clear.

Source files
------------

// File: rtl/jk_mod_counter.sv
// -----------------------------------------------------------------------------
// jk_mod_counter
//
// Synchronous modulo-MODULUS up/down counter built from JK flip-flop
// excitation. Each cycle the desired next count is computed, converted to
// per-bit J/K excitation, and the state register is advanced only through the
// JK characteristic equation q+ = J&~q | ~K&q. The J/K vectors are exported so
// they can be cross-checked against discrete flip-flop instances upstream.
//
// Parameters:
//   WIDTH    counter bit width, 1..16
//   MODULUS  count range 0..MODULUS-1, 2..2**WIDTH
//
// Ports:
//   clock   in   rising-edge clock for all state
//   clear   in   asynchronous active-high reset (q=0, wrap=0)
//   en      in   count enable
//   up      in   direction, 1 = increment, 0 = decrement
//   load    in   synchronous parallel load (clamped to MODULUS-1)
//   din     in   load value
//   q       out  registered count
//   qbar    out  bitwise complement of q
//   j_vec   out  combinational J excitation for the next edge
//   k_vec   out  combinational K excitation for the next edge
//   tc      out  combinational terminal count (next enabled edge wraps)
//   wrap    out  registered one-cycle pulse following a wrapping edge
// -----------------------------------------------------------------------------
module jk_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] j_vec,
    output logic [WIDTH-1:0] k_vec,
    output logic             tc,
    output logic             wrap
);

    // Reject illegal configurations at elaboration rather than building a
    // counter whose range cannot be represented.
    generate
        if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_config
            $error("jk_mod_counter: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_next;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (q == MAX_COUNT);
    assign at_zero = (q == '0);

    // Desired next count, priority load > en > hold (clear is handled by the
    // asynchronous reset of the register).
    always_comb begin
        // NOTE: assigning a default first guarantees every path drives q_next,
        // so no latch is inferred.
        q_next = q;
        if (load) begin
            q_next = (din > MAX_COUNT) ? MAX_COUNT : din;
        end else if (en) begin
            if (up) begin
                q_next = at_max ? '0 : q + WIDTH'(1);
            end else begin
                q_next = at_zero ? MAX_COUNT : q - WIDTH'(1);
            end
        end
    end

    // JK excitation: set bits rising 0->1, reset bits falling 1->0. Bits that
    // stay put get j=k=0, so the toggle code j=k=1 never occurs.
    assign j_vec = ~q & q_next;
    assign k_vec = q & ~q_next;

    assign qbar = ~q;

    // Terminal count: the next edge will wrap the counter.
    assign tc = en & ~load & ((up & at_max) | (~up & at_zero));

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all state updates on this
            // edge based on pre-edge values, matching real flip-flops.
            q    <= (j_vec & ~q) | (~k_vec & q);
            wrap <= tc;
        end
    end

endmodule

// File: tb/tb_jk_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_jk_mod_counter
//
// Drives three builds of jk_mod_counter from shared stimulus:
//   m10 : WIDTH=4, MODULUS=10 (directed scenarios + random)
//   m2  : WIDTH=2, MODULUS=2  (back-to-back wraps, clamping of din 2..3)
//   m16 : WIDTH=4, MODULUS=16 (power-of-two natural wrap)
// Expected values come from integer modulo arithmetic in the bench.
// -----------------------------------------------------------------------------
module tb_jk_mod_counter;

    logic       clock = 1'b0;
    logic       clear;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] din;

    logic [3:0] q_a, qb_a, j_a, k_a;
    logic       tc_a, wr_a;
    logic [1:0] q_b, qb_b, j_b, k_b;
    logic       tc_b, wr_b;
    logic [3:0] q_c, qb_c, j_c, k_c;
    logic       tc_c, wr_c;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state per build: current count and current wrap output.
    int mq[3];
    int mw[3];

    always #5 clock = ~clock;

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut_m10 (
        .clock(clock), .clear(clear), .en(en), .up(up), .load(load), .din(din),
        .q(q_a), .qbar(qb_a), .j_vec(j_a), .k_vec(k_a), .tc(tc_a), .wrap(wr_a)
    );

    jk_mod_counter #(.WIDTH(2), .MODULUS(2)) dut_m2 (
        .clock(clock), .clear(clear), .en(en), .up(up), .load(load), .din(din[1:0]),
        .q(q_b), .qbar(qb_b), .j_vec(j_b), .k_vec(k_b), .tc(tc_b), .wrap(wr_b)
    );

    jk_mod_counter #(.WIDTH(4), .MODULUS(16)) dut_m16 (
        .clock(clock), .clear(clear), .en(en), .up(up), .load(load), .din(din),
        .q(q_c), .qbar(qb_c), .j_vec(j_c), .k_vec(k_c), .tc(tc_c), .wrap(wr_c)
    );

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Next count from the counting rules, in plain integer arithmetic.
    function automatic int next_count(input int m, input int qv, input logic e,
                                      input logic u, input logic l, input int d);
        if (l)  return (d > m - 1) ? m - 1 : d;
        if (!e) return qv;
        if (u)  return (qv + 1) % m;
        return (qv + m - 1) % m;
    endfunction

    // True when an enabled count step would leave the range 0..m-1.
    function automatic bit leaves_range(input int m, input int qv, input logic e,
                                        input logic u, input logic l);
        if (!e || l) return 1'b0;
        return u ? (qv + 1 >= m) : (qv - 1 < 0);
    endfunction

    task automatic comb_check(input string name, input int mask, input int qm,
                              input int nq, input bit exp_tc, input int qb_o,
                              input int j_o, input int k_o, input logic tc_o);
        check({name, "_tc"},   int'(tc_o), int'(exp_tc));
        check({name, "_qbar"}, qb_o, ~qm & mask);
        check({name, "_j"},    j_o,  ~qm & nq & mask);
        check({name, "_k"},    k_o,  qm & ~nq & mask);
        check({name, "_jk0"},  j_o & k_o, 0);
    endtask

    // One clock cycle: apply inputs after the falling edge, check the
    // combinational outputs, then check registered outputs after the edge.
    task automatic step(input logic e, input logic u, input logic l, input logic [3:0] d);
        int nq[3];
        bit nw[3];
        @(negedge clock);
        clear = 1'b0;
        en    = e;
        up    = u;
        load  = l;
        din   = d;
        #1;
        nq[0] = next_count(10, mq[0], e, u, l, int'(d));
        nq[1] = next_count(2,  mq[1], e, u, l, int'(d[1:0]));
        nq[2] = next_count(16, mq[2], e, u, l, int'(d));
        nw[0] = leaves_range(10, mq[0], e, u, l);
        nw[1] = leaves_range(2,  mq[1], e, u, l);
        nw[2] = leaves_range(16, mq[2], e, u, l);
        comb_check("m10", 15, mq[0], nq[0], nw[0], int'(qb_a), int'(j_a), int'(k_a), tc_a);
        comb_check("m2",  3,  mq[1], nq[1], nw[1], int'(qb_b), int'(j_b), int'(k_b), tc_b);
        comb_check("m16", 15, mq[2], nq[2], nw[2], int'(qb_c), int'(j_c), int'(k_c), tc_c);
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) begin
            mq[i] = nq[i];
            mw[i] = int'(nw[i]);
        end
        check("m10_q",    int'(q_a),  mq[0]);
        check("m10_wrap", int'(wr_a), mw[0]);
        check("m2_q",     int'(q_b),  mq[1]);
        check("m2_wrap",  int'(wr_b), mw[1]);
        check("m16_q",    int'(q_c),  mq[2]);
        check("m16_wrap", int'(wr_c), mw[2]);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_m10_q"},    int'(q_a),  0);
        check({tag, "_m10_wrap"}, int'(wr_a), 0);
        check({tag, "_m2_q"},     int'(q_b),  0);
        check({tag, "_m16_q"},    int'(q_c),  0);
        check({tag, "_m16_qbar"}, int'(qb_c), 15);
    endtask

    // Assert clear between edges and hold it across 'edges' rising edges.
    // The following step() releases it at a falling edge.
    task automatic do_clear(input int edges);
        @(negedge clock);
        #2;
        clear = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            mq[i] = 0;
            mw[i] = 0;
        end
        check_cleared("clr_async");
        for (int n = 0; n < edges; n++) begin
            @(posedge clock);
            #1;
            check_cleared("clr_hold");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        clear = 1'b0;
        en    = 1'b0;
        up    = 1'b0;
        load  = 1'b0;
        din   = '0;

        // 1. Reset mid-cycle, then count up through the wrap.
        #2;
        clear = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            mq[i] = 0;
            mw[i] = 0;
        end
        check_cleared("reset");
        for (int n = 0; n < 12; n++) step(1'b1, 1'b1, 1'b0, 4'd0);
        check("t1_final_q", int'(q_a), 2);

        // 2. Count down across zero.
        step(1'b0, 1'b0, 1'b1, 4'd1);
        for (int n = 0; n < 3; n++) step(1'b1, 1'b0, 1'b0, 4'd0);
        check("t2_final_q", int'(q_a), 8);

        // 3. Load clamp overrides count, then an in-range load.
        step(1'b1, 1'b1, 1'b1, 4'd12);
        check("t3_clamp_q", int'(q_a), 9);
        check("t3_clamp_wrap", int'(wr_a), 0);
        step(1'b1, 1'b1, 1'b1, 4'd5);
        check("t3_load_q", int'(q_a), 5);

        // 4. Hold at 7, then 7->8 excitation.
        step(1'b0, 1'b0, 1'b1, 4'd7);
        for (int n = 0; n < 4; n++) step(1'b0, 1'b1, 1'b0, 4'd0);
        step(1'b1, 1'b1, 1'b0, 4'd0);
        check("t4_q8", int'(q_a), 8);

        // 5. Async clear mid-count.
        step(1'b0, 1'b0, 1'b1, 4'd5);
        step(1'b1, 1'b1, 1'b0, 4'd0);
        check("t5_q6", int'(q_a), 6);
        do_clear(2);
        step(1'b1, 1'b1, 1'b0, 4'd0);
        check("t5_release_q", int'(q_a), 1);

        // 6. Random regression across all three builds.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 99) < 3) begin
                do_clear(int'($urandom_range(0, 2)));
            end else begin
                step($urandom_range(0, 3) != 0,
                     1'($urandom_range(0, 1)),
                     $urandom_range(0, 9) == 0,
                     4'($urandom_range(0, 15)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
